// File: rtl/vga_scan_timing.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vga_scan_timing                                              |
// | Description : Raster scan generator for the sprite renderer. Produces      |
// |               line/column coordinates, VGA syncs, active-video flag and    |
// |               a per-frame tick, and gates the returned renderer pixel      |
// |               onto the RGB channels. Default timing is 640x480 @ 60 Hz.    |
// | Options     : VGA_SYNC_ALIGN_EN - delay hsync/vsync/video_on by one pclk   |
// |               so they line up with the renderer's registered pixel.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module vga_scan_timing #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0,
  parameter int COLOR_W   = 4
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               pixel_in,
  output logic [9:0]         x,
  output logic [9:0]         y,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               frame_tick,
  output logic [COLOR_W-1:0] vga_r,
  output logic [COLOR_W-1:0] vga_g,
  output logic [COLOR_W-1:0] vga_b
);

  localparam int         c_h_total  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int         c_v_total  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] c_h_last   = 10'(c_h_total - 1);
  localparam logic [9:0] c_v_last   = 10'(c_v_total - 1);
  localparam logic [9:0] c_h_vis    = 10'(H_VISIBLE);
  localparam logic [9:0] c_v_vis    = 10'(V_VISIBLE);
  localparam logic [9:0] c_hs_start = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] c_hs_end   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] c_vs_start = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] c_vs_end   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic       c_sync_on  = SYNC_POL;
  localparam logic       c_sync_off = ~SYNC_POL;

  logic [9:0] r_hc;
  logic [9:0] r_vc;
  logic [9:0] r_x;
  logic [9:0] r_y;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_video_on;
  logic       r_frame_tick;
  logic       w_h_last;
  logic       w_v_last;
  logic       w_video_on_g;
  logic       w_pix_on;

  assign w_h_last = (r_hc == c_h_last);
  assign w_v_last = (r_vc == c_v_last);

  // Column counter runs every pclk; line counter advances when the column wraps.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_hc <= 10'd0;
      r_vc <= 10'd0;
    end else if (w_h_last) begin
      r_hc <= 10'd0;
      r_vc <= w_v_last ? 10'd0 : r_vc + 10'd1;
    end else begin
      r_hc <= r_hc + 10'd1;
    end
  end

  // Output stage: every timing output is decoded from the same counter value, so all stay aligned.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_x          <= 10'd0;
      r_y          <= 10'd0;
      r_hsync      <= c_sync_off;
      r_vsync      <= c_sync_off;
      r_video_on   <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_x          <= r_vc;
      r_y          <= r_hc;
      r_hsync      <= (r_hc >= c_hs_start && r_hc <= c_hs_end) ? c_sync_on : c_sync_off;
      r_vsync      <= (r_vc >= c_vs_start && r_vc <= c_vs_end) ? c_sync_on : c_sync_off;
      r_video_on   <= (r_hc < c_h_vis) && (r_vc < c_v_vis);
      r_frame_tick <= w_h_last && w_v_last;
    end
  end

  assign x          = r_x;
  assign y          = r_y;
  assign frame_tick = r_frame_tick;

`ifdef VGA_SYNC_ALIGN_EN
  logic r_hsync_d;
  logic r_vsync_d;
  logic r_video_on_d;

  // Extra stage so syncs and blanking match the renderer's one-pclk pixel latency.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_hsync_d    <= c_sync_off;
      r_vsync_d    <= c_sync_off;
      r_video_on_d <= 1'b0;
    end else begin
      r_hsync_d    <= r_hsync;
      r_vsync_d    <= r_vsync;
      r_video_on_d <= r_video_on;
    end
  end

  assign hsync        = r_hsync_d;
  assign vsync        = r_vsync_d;
  assign video_on     = r_video_on_d;
  assign w_video_on_g = r_video_on_d;
`else
  // Without the align stage the colour trails the syncs by one column (bring-up only).
  assign hsync        = r_hsync;
  assign vsync        = r_vsync;
  assign video_on     = r_video_on;
  assign w_video_on_g = r_video_on;
`endif

  // Blanking gate: the renderer pixel only reaches the DAC inside the visible window.
  assign w_pix_on = pixel_in & w_video_on_g;
  assign vga_r    = {COLOR_W{w_pix_on}};
  assign vga_g    = {COLOR_W{w_pix_on}};
  assign vga_b    = {COLOR_W{w_pix_on}};

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_timing.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_vga_scan_timing                                           |
// | Description : Scoreboard bench for vga_scan_timing. A default 640x480      |
// |               instance and a shrunken active-high-sync instance share      |
// |               stimulus; expected outputs come from a cycle-index model.    |
// | Options     : VGA_SYNC_ALIGN_EN - model the delayed sync/blank stage.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_vga_scan_timing;

  logic       pclk = 1'b0;
  logic       rst;
  logic       pixel_in;

  logic [9:0] d_x, d_y, s_x, s_y;
  logic       d_hsync, d_vsync, d_video_on, d_frame_tick;
  logic       s_hsync, s_vsync, s_video_on, s_frame_tick;
  logic [3:0] d_r, d_g, d_b, s_r, s_g, s_b;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       von;
    logic       ft;
    logic [3:0] col;
  } exp_t;

  exp_t q_d[$];
  exp_t q_s[$];
  int   checks   = 0;
  int   failures = 0;
  int   k        = 0;

  always #20 pclk = ~pclk;

  vga_scan_timing dut_d (
    .pclk(pclk), .rst(rst), .pixel_in(pixel_in),
    .x(d_x), .y(d_y), .hsync(d_hsync), .vsync(d_vsync),
    .video_on(d_video_on), .frame_tick(d_frame_tick),
    .vga_r(d_r), .vga_g(d_g), .vga_b(d_b)
  );

  vga_scan_timing #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(4),
    .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .SYNC_POL(1'b1), .COLOR_W(4)
  ) dut_s (
    .pclk(pclk), .rst(rst), .pixel_in(pixel_in),
    .x(s_x), .y(s_y), .hsync(s_hsync), .vsync(s_vsync),
    .video_on(s_video_on), .frame_tick(s_frame_tick),
    .vga_r(s_r), .vga_g(s_g), .vga_b(s_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    if (obs !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, want, $time);
    end
  endtask

  // k = pclk edges since reset released (0 = in reset, nothing clocked yet).
  function automatic exp_t model(input int kk, input int hv, input int hf, input int hsw,
                                 input int hb, input int vv, input int vf, input int vsw,
                                 input int vb, input bit pol, input bit pix);
    exp_t e;
    int   ht, vt, idx, h, v;
    ht    = hv + hf + hsw + hb;
    vt    = vv + vf + vsw + vb;
    e.x   = '0;
    e.y   = '0;
    e.hs  = ~pol;
    e.vs  = ~pol;
    e.von = 1'b0;
    e.ft  = 1'b0;
    if (kk > 0) begin
      idx  = kk - 1;
      h    = idx % ht;
      v    = (idx / ht) % vt;
      e.y  = 10'(h);
      e.x  = 10'(v);
      e.ft = (h == ht - 1) && (v == vt - 1);
`ifdef VGA_SYNC_ALIGN_EN
      if (kk > 1) begin
        h = (idx - 1) % ht;
        v = ((idx - 1) / ht) % vt;
        e.hs  = (h >= hv + hf && h < hv + hf + hsw) ? pol : ~pol;
        e.vs  = (v >= vv + vf && v < vv + vf + vsw) ? pol : ~pol;
        e.von = (h < hv) && (v < vv);
      end
`else
      e.hs  = (h >= hv + hf && h < hv + hf + hsw) ? pol : ~pol;
      e.vs  = (v >= vv + vf && v < vv + vf + vsw) ? pol : ~pol;
      e.von = (h < hv) && (v < vv);
`endif
    end
    e.col = {4{pix & e.von}};
    return e;
  endfunction

  task automatic push_exp();
    q_d.push_back(model(k, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, pixel_in));
    q_s.push_back(model(k, 16, 2, 3, 4, 12, 2, 2, 3, 1'b1, pixel_in));
  endtask

  task automatic cycle(input bit pix);
    @(posedge pclk);
    if (!rst) k++;
    #1;
    pixel_in = pix;
    push_exp();
  endtask

  task automatic cmp(input string p, input exp_t e, input logic [9:0] ox, input logic [9:0] oy,
                     input logic ohs, input logic ovs, input logic ovon, input logic oft,
                     input logic [3:0] orr, input logic [3:0] og, input logic [3:0] ob);
    check({p, ".x"},          32'(ox),   32'(e.x));
    check({p, ".y"},          32'(oy),   32'(e.y));
    check({p, ".hsync"},      32'(ohs),  32'(e.hs));
    check({p, ".vsync"},      32'(ovs),  32'(e.vs));
    check({p, ".video_on"},   32'(ovon), 32'(e.von));
    check({p, ".frame_tick"}, 32'(oft),  32'(e.ft));
    check({p, ".vga_r"},      32'(orr),  32'(e.col));
    check({p, ".vga_g"},      32'(og),   32'(e.col));
    check({p, ".vga_b"},      32'(ob),   32'(e.col));
  endtask

  // Monitor: outputs are settled mid-cycle, compare against the oldest expectation.
  always @(negedge pclk) begin
    exp_t e;
    if (q_d.size() > 0) begin
      e = q_d.pop_front();
      cmp("def", e, d_x, d_y, d_hsync, d_vsync, d_video_on, d_frame_tick, d_r, d_g, d_b);
    end
    if (q_s.size() > 0) begin
      e = q_s.pop_front();
      cmp("sml", e, s_x, s_y, s_hsync, s_vsync, s_video_on, s_frame_tick, s_r, s_g, s_b);
    end
  end

  initial begin
    rst      = 1'b1;
    pixel_in = 1'b1;
    k        = 0;
    // Reset held with pclk running and pixel high: colour must stay blanked.
    repeat (3) cycle(1'b1);
    rst = 1'b0;
    // Pixel held high across more than a full default line: exercises blanking.
    repeat (900) cycle(1'b1);
    // Random pixels across line wrap and several small-instance frames.
    repeat (900) cycle(1'($urandom_range(0, 1)));

    // Short asynchronous reset pulse entirely between clock edges.
    @(posedge pclk);
    #1;
    pixel_in = 1'b1;
    rst      = 1'b1;
    #2;
    check("arst.def.x",        32'(d_x),          32'd0);
    check("arst.def.y",        32'(d_y),          32'd0);
    check("arst.def.hsync",    32'(d_hsync),      32'd1);
    check("arst.def.vsync",    32'(d_vsync),      32'd1);
    check("arst.def.video_on", 32'(d_video_on),   32'd0);
    check("arst.def.ftick",    32'(d_frame_tick), 32'd0);
    check("arst.def.vga_r",    32'(d_r),          32'd0);
    check("arst.sml.x",        32'(s_x),          32'd0);
    check("arst.sml.y",        32'(s_y),          32'd0);
    check("arst.sml.hsync",    32'(s_hsync),      32'd0);
    check("arst.sml.vsync",    32'(s_vsync),      32'd0);
    check("arst.sml.video_on", 32'(s_video_on),   32'd0);
    check("arst.sml.vga_g",    32'(s_g),          32'd0);
    #5;
    rst = 1'b0;
    k   = 0;
    push_exp();

    // Scan must restart from line 0, column 0.
    repeat (1200) cycle(1'($urandom_range(0, 1)));

    @(negedge pclk);
    #1;
    check("queue.def.drained", 32'(q_d.size()), 32'd0);
    check("queue.sml.drained", 32'(q_s.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
